pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the hold/flush controls of the PC, IF/ID and ID/EX state registers for four cases: load-use hazards, taken branches resolved in EX, multi-cycle mul/div waits, and interrupt entry. Interrupt entry includes EPC capture and vector redirect. It also keeps a saturating stall-cycle performance counter.

Parameters:
DRAIN_CYCLES, 2, cycles spent draining EX/MEM/WB before vectoring on interrupt (1..7)
MD_TIMEOUT, 64, maximum cycles waiting for md_done before aborting wait (2..255)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_pc  in  32  PC of instruction in ID
ex_memread  in  1  load in EX
ex_regdest  in  5  destination register of instruction in EX
ex_branch_taken  in  1  branch/jump resolved taken in EX
ex_branch_target  in  32  target of taken branch
ex_md_start  in  1  mul/div issued from EX this cycle
md_done  in  1  mul/div result valid (pulse)
irq_req  in  1  level interrupt request
irq_en  in  1  interrupt enable
pc_hold  out  1  PC register holds
ifid_hold  out  1  IF/ID holds (stall input)
ifid_flush  out  1  IF/ID loads NOP
idex_bubble  out  1  ID/EX loads NOP (reset-style clear)
pc_vec_sel  out  1  PC next = exception vector
irq_ack  out  1  one-cycle acknowledge
epc  out  32  captured return PC
md_timeout  out  1  sticky error, mul/div wait aborted
stall_cycles  out  CNT_W  saturating count of cycles with pc_hold=1

Behaviour:
- States: RUN, MD_WAIT, DRAIN, VECTOR. Reset -> RUN. epc=0, md_timeout=0, stall_cycles=0.
- While reset=1, all control outputs read 0. A reset mid-sequence abandons the sequence and returns to RUN next cycle.
- Control outputs are combinational from state and inputs, with zero-cycle latency. State, epc, counters and md_timeout are registered.
- Load-use hazard: lu = ex_memread & ex_regdest!=0 & ((id_use_rs & ex_regdest==id_rs) | (id_use_rt & ex_regdest==id_rt)).
- RUN priority, highest first:
  1. irq_req&irq_en: go to DRAIN. Capture epc = ex_branch_taken ? ex_branch_target : id_pc. Assert ifid_flush, idex_bubble, pc_hold this cycle.
  2. ex_md_start: go to MD_WAIT. Assert pc_hold, ifid_hold, idex_bubble.
  3. ex_branch_taken: assert ifid_flush and idex_bubble. No hold. Stay in RUN.
  4. lu: assert pc_hold, ifid_hold, idex_bubble for exactly this cycle. Stay in RUN; a lu that persists next cycle stalls again.
- MD_WAIT:
  - Assert pc_hold, ifid_hold, idex_bubble every cycle.
  - Wait counter starts at 1 on entry.
  - md_done: go to RUN. The done cycle is still stalled.
  - Counter reaching MD_TIMEOUT without md_done: set md_timeout (sticky until reset) and go to RUN.
  - irq_req is ignored in MD_WAIT and is taken in RUN afterwards.
- DRAIN:
  - Assert pc_hold, ifid_flush, idex_bubble each cycle.
  - Counter runs DRAIN_CYCLES cycles, then go to VECTOR.
  - ex_branch_taken inside DRAIN is ignored, since EX holds bubbles.
- VECTOR (1 cycle): pc_vec_sel=1, irq_ack=1, ifid_flush=1, pc_hold=0. Then RUN.
- irq_req still high after VECTOR is re-evaluated in RUN. Software must clear it or drop irq_en.
- stall_cycles increments each cycle pc_hold=1 and saturates at all-ones.
- epc changes only on DRAIN entry.

Test Plan:
- Load-use: ex_memread=1, ex_regdest=8, id_rs=8, id_use_rs=1 for 1 cycle -> pc_hold=ifid_hold=idex_bubble=1 that cycle only. stall_cycles 0->1. Same setup with ex_regdest=0 -> no stall.
- Branch: ex_branch_taken=1 with lu also true -> ifid_flush=idex_bubble=1, pc_hold=0.
- Mul/div: ex_md_start, md_done 5 cycles later -> stall held for 6 cycles, then RUN. No md_done -> md_timeout=1 after 64 cycles and pipeline released.
- IRQ: irq_req=irq_en=1, id_pc=0x00400010 -> epc=0x00400010. DRAIN for 2 cycles with flushes, then one cycle of pc_vec_sel=irq_ack=1. Repeat with ex_branch_taken, target 0x00400100 -> epc=0x00400100.
- IRQ during MD_WAIT: irq raised on cycle 2 of wait -> no ack until after md_done. DRAIN starts the cycle after return to RUN.
- Reset asserted in DRAIN -> all outputs 0 that cycle. RUN next cycle, epc=0, stall_cycles=0. Preload near saturation -> stall_cycles holds at 0xFFFF.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// Pipeline-to-hazard-controller signal bundle.
// The slave side is the controller; the master side is the pipeline datapath.
interface pipe_hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [31:0]      id_pc;
    logic             ex_memread;
    logic [4:0]       ex_regdest;
    logic             ex_branch_taken;
    logic [31:0]      ex_branch_target;
    logic             ex_md_start;
    logic             md_done;
    logic             irq_req;
    logic             irq_en;

    logic             pc_hold;
    logic             ifid_hold;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pc_vec_sel;
    logic             irq_ack;
    logic [31:0]      epc;
    logic             md_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_pc,
               ex_memread, ex_regdest, ex_branch_taken, ex_branch_target,
               ex_md_start, md_done, irq_req, irq_en,
        input  pc_hold, ifid_hold, ifid_flush, idex_bubble, pc_vec_sel,
               irq_ack, epc, md_timeout, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_pc,
               ex_memread, ex_regdest, ex_branch_taken, ex_branch_target,
               ex_md_start, md_done, irq_req, irq_en,
        output pc_hold, ifid_hold, ifid_flush, idex_bubble, pc_vec_sel,
               irq_ack, epc, md_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch,
// mul/div wait and interrupt entry, plus a saturating stall-cycle counter.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_RUN     | normal issue; resolves irq > mul/div > branch > load-use
// S_MD_WAIT | pipeline frozen until md_done or the wait timer expires
// S_DRAIN   | front end flushed while EX/MEM/WB empty out
// S_VECTOR  | one cycle redirecting PC to the exception vector, irq acked
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int MD_TIMEOUT   = 64,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_if.slave      bus
);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_MD_WAIT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_VECTOR  = 2'd3;

    // Down-counter loads: terminal count 0 marks the last cycle of the phase.
    localparam logic [7:0] MD_LOAD    = 8'(MD_TIMEOUT - 1);
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [7:0]       tmr;
    logic [7:0]       tmr_nxt;
    logic [31:0]      epc_q;
    logic             md_timeout_q;
    logic [CNT_W-1:0] stall_q;

    logic lu;
    logic irq_take;
    logic epc_load;
    logic md_err_set;
    logic pc_hold_c;
    logic ifid_hold_c;
    logic ifid_flush_c;
    logic idex_bubble_c;
    logic pc_vec_sel_c;
    logic irq_ack_c;

    assign lu = bus.ex_memread && (bus.ex_regdest != 5'd0) &&
                ((bus.id_use_rs && (bus.ex_regdest == bus.id_rs)) ||
                 (bus.id_use_rt && (bus.ex_regdest == bus.id_rt)));

    assign irq_take = bus.irq_req && bus.irq_en;

    always_comb begin
        state_nxt     = state;
        tmr_nxt       = tmr;
        epc_load      = 1'b0;
        md_err_set    = 1'b0;
        pc_hold_c     = 1'b0;
        ifid_hold_c   = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        pc_vec_sel_c  = 1'b0;
        irq_ack_c     = 1'b0;

        case (state)
            S_RUN: begin
                if (irq_take) begin
                    state_nxt     = S_DRAIN;
                    tmr_nxt       = DRAIN_LOAD;
                    epc_load      = 1'b1;
                    pc_hold_c     = 1'b1;
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (bus.ex_md_start) begin
                    state_nxt     = S_MD_WAIT;
                    tmr_nxt       = MD_LOAD;
                    pc_hold_c     = 1'b1;
                    ifid_hold_c   = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (bus.ex_branch_taken) begin
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (lu) begin
                    pc_hold_c     = 1'b1;
                    ifid_hold_c   = 1'b1;
                    idex_bubble_c = 1'b1;
                end
            end

            S_MD_WAIT: begin
                pc_hold_c     = 1'b1;
                ifid_hold_c   = 1'b1;
                idex_bubble_c = 1'b1;
                // A done pulse on the final timer cycle still counts as success.
                if (bus.md_done) begin
                    state_nxt = S_RUN;
                end else if (tmr == 8'd0) begin
                    state_nxt  = S_RUN;
                    md_err_set = 1'b1;
                end else begin
                    tmr_nxt = tmr - 8'd1;
                end
            end

            S_DRAIN: begin
                pc_hold_c     = 1'b1;
                ifid_flush_c  = 1'b1;
                idex_bubble_c = 1'b1;
                if (tmr == 8'd0) begin
                    state_nxt = S_VECTOR;
                end else begin
                    tmr_nxt = tmr - 8'd1;
                end
            end

            S_VECTOR: begin
                pc_vec_sel_c = 1'b1;
                irq_ack_c    = 1'b1;
                ifid_flush_c = 1'b1;
                state_nxt    = S_RUN;
            end

            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_RUN;
            tmr          <= 8'd0;
            epc_q        <= 32'd0;
            md_timeout_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            if (epc_load) begin
                epc_q <= bus.ex_branch_taken ? bus.ex_branch_target : bus.id_pc;
            end
            if (md_err_set) begin
                md_timeout_q <= 1'b1;
            end
            if (pc_hold_c && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Controls are forced low while reset is held, whatever the state.
    assign bus.pc_hold      = pc_hold_c     & ~reset;
    assign bus.ifid_hold    = ifid_hold_c   & ~reset;
    assign bus.ifid_flush   = ifid_flush_c  & ~reset;
    assign bus.idex_bubble  = idex_bubble_c & ~reset;
    assign bus.pc_vec_sel   = pc_vec_sel_c  & ~reset;
    assign bus.irq_ack      = irq_ack_c     & ~reset;
    assign bus.epc          = epc_q;
    assign bus.md_timeout   = md_timeout_q;
    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected control vectors are queued
// as each cycle's stimulus is applied and compared on the following falling edge.
module tb_pipe_hazard_ctrl;

    // {pc_hold, ifid_hold, ifid_flush, idex_bubble, pc_vec_sel, irq_ack}
    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_STALL = 6'b110100;
    localparam logic [5:0] C_FLUSH = 6'b001100;
    localparam logic [5:0] C_DRAIN = 6'b101100;
    localparam logic [5:0] C_VEC   = 6'b001011;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipe_hazard_if #(.CNT_W(16)) bus ();
    pipe_hazard_if #(.CNT_W(4))  sbus ();

    pipe_hazard_ctrl #(.DRAIN_CYCLES(2), .MD_TIMEOUT(64), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    pipe_hazard_ctrl #(.DRAIN_CYCLES(2), .MD_TIMEOUT(64), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus.slave)
    );

    typedef struct {
        string      tag;
        logic [5:0] ctrl;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    int   checks    = 0;
    int   failures  = 0;
    int   exp_stall = 0;

    logic [5:0] ctrl_obs;
    assign ctrl_obs = {bus.pc_hold, bus.ifid_hold, bus.ifid_flush,
                       bus.idex_bubble, bus.pc_vec_sel, bus.irq_ack};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_e = sb_q.pop_front();
            check_val(sb_e.tag, 64'(ctrl_obs), 64'(sb_e.ctrl));
        end
    end

    task automatic idle();
        bus.id_rs            = 5'd0;
        bus.id_rt            = 5'd0;
        bus.id_use_rs        = 1'b0;
        bus.id_use_rt        = 1'b0;
        bus.id_pc            = 32'd0;
        bus.ex_memread       = 1'b0;
        bus.ex_regdest       = 5'd0;
        bus.ex_branch_taken  = 1'b0;
        bus.ex_branch_target = 32'd0;
        bus.ex_md_start      = 1'b0;
        bus.md_done          = 1'b0;
        bus.irq_req          = 1'b0;
        bus.irq_en           = 1'b0;
    endtask

    task automatic idle_sat();
        sbus.id_rs            = 5'd0;
        sbus.id_rt            = 5'd0;
        sbus.id_use_rs        = 1'b0;
        sbus.id_use_rt        = 1'b0;
        sbus.id_pc            = 32'd0;
        sbus.ex_memread       = 1'b0;
        sbus.ex_regdest       = 5'd0;
        sbus.ex_branch_taken  = 1'b0;
        sbus.ex_branch_target = 32'd0;
        sbus.ex_md_start      = 1'b0;
        sbus.md_done          = 1'b0;
        sbus.irq_req          = 1'b0;
        sbus.irq_en           = 1'b0;
    endtask

    // Queue the expected controls for the inputs now applied, then advance one cycle.
    task automatic cyc(input string tag, input logic [5:0] exp);
        exp_t e;
        e.tag  = tag;
        e.ctrl = exp;
        sb_q.push_back(e);
        if (exp[5]) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic [4:0] dest, input logic [4:0] rs, input logic use_rs,
                          input logic [4:0] rt, input logic use_rt);
        idle();
        bus.ex_memread = 1'b1;
        bus.ex_regdest = dest;
        bus.id_rs      = rs;
        bus.id_use_rs  = use_rs;
        bus.id_rt      = rt;
        bus.id_use_rt  = use_rt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        idle_sat();
        @(posedge clk);
        #1;

        // Reset dominates even with irq and load-use present
        set_lu(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
        bus.irq_req = 1'b1;
        bus.irq_en  = 1'b1;
        cyc("rst_outs", C_NONE);
        reset = 1'b0;
        idle();
        check_val("rst_epc", 64'(bus.epc), 64'h0);
        check_val("rst_mdto", 64'(bus.md_timeout), 64'h0);
        check_val("rst_stall", 64'(bus.stall_cycles), 64'h0);
        cyc("rst_idle", C_NONE);

        // Load-use variants
        set_lu(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
        cyc("lu_rs", C_STALL);
        idle();
        check_val("lu_stall1", 64'(bus.stall_cycles), 64'd1);
        cyc("lu_rs_after", C_NONE);
        set_lu(5'd8, 5'd3, 1'b1, 5'd8, 1'b1);
        cyc("lu_rt", C_STALL);
        set_lu(5'd8, 5'd8, 1'b0, 5'd0, 1'b0);
        cyc("lu_rs_unused", C_NONE);
        set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        cyc("lu_r0", C_NONE);
        set_lu(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
        bus.ex_memread = 1'b0;
        cyc("lu_no_load", C_NONE);
        set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        cyc("lu_persist0", C_STALL);
        cyc("lu_persist1", C_STALL);
        idle();
        check_val("lu_stall4", 64'(bus.stall_cycles), 64'(exp_stall));

        // Taken branch beats load-use
        set_lu(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
        bus.ex_branch_taken = 1'b1;
        cyc("br_over_lu", C_FLUSH);
        idle();
        cyc("br_after", C_NONE);

        // Mul/div with done five cycles after start
        bus.ex_md_start = 1'b1;
        cyc("md_start", C_STALL);
        idle();
        for (int i = 1; i <= 4; i++) begin
            bus.ex_branch_taken = (i == 2);
            cyc($sformatf("md_wait%0d", i), C_STALL);
        end
        idle();
        bus.md_done = 1'b1;
        cyc("md_done_cyc", C_STALL);
        idle();
        cyc("md_release", C_NONE);
        check_val("md_stall", 64'(bus.stall_cycles), 64'(exp_stall));
        check_val("md_no_to", 64'(bus.md_timeout), 64'h0);

        // Interrupt entry from id_pc; branch inside DRAIN must be ignored
        bus.irq_req = 1'b1;
        bus.irq_en  = 1'b1;
        bus.id_pc   = 32'h0040_0010;
        cyc("irq_entry", C_DRAIN);
        idle();
        check_val("irq_epc", 64'(bus.epc), 64'h0040_0010);
        cyc("irq_drain1", C_DRAIN);
        bus.ex_branch_taken  = 1'b1;
        bus.ex_branch_target = 32'h0000_1234;
        cyc("irq_drain2", C_DRAIN);
        idle();
        cyc("irq_vector", C_VEC);
        cyc("irq_done", C_NONE);
        check_val("irq_epc_kept", 64'(bus.epc), 64'h0040_0010);

        bus.irq_req = 1'b1;
        cyc("irq_masked", C_NONE);
        idle();

        // Interrupt entry with a taken branch in EX
        bus.irq_req          = 1'b1;
        bus.irq_en           = 1'b1;
        bus.id_pc            = 32'h0040_0020;
        bus.ex_branch_taken  = 1'b1;
        bus.ex_branch_target = 32'h0040_0100;
        cyc("irqbr_entry", C_DRAIN);
        idle();
        check_val("irqbr_epc", 64'(bus.epc), 64'h0040_0100);
        cyc("irqbr_drain1", C_DRAIN);
        cyc("irqbr_drain2", C_DRAIN);
        cyc("irqbr_vector", C_VEC);
        cyc("irqbr_done", C_NONE);

        // Interrupt raised during MD_WAIT waits for md_done
        bus.ex_md_start = 1'b1;
        cyc("mdirq_start", C_STALL);
        idle();
        cyc("mdirq_wait1", C_STALL);
        bus.irq_req = 1'b1;
        bus.irq_en  = 1'b1;
        bus.id_pc   = 32'h0040_0040;
        cyc("mdirq_wait2", C_STALL);
        bus.md_done = 1'b1;
        cyc("mdirq_done", C_STALL);
        bus.md_done = 1'b0;
        cyc("mdirq_entry", C_DRAIN);
        idle();
        check_val("mdirq_epc", 64'(bus.epc), 64'h0040_0040);
        cyc("mdirq_drain1", C_DRAIN);
        cyc("mdirq_drain2", C_DRAIN);
        cyc("mdirq_vector", C_VEC);
        cyc("mdirq_done2", C_NONE);
        check_val("mdirq_stall", 64'(bus.stall_cycles), 64'(exp_stall));

        // Mul/div timeout after 64 wait cycles
        bus.ex_md_start = 1'b1;
        cyc("mdto_start", C_STALL);
        idle();
        for (int i = 1; i <= 64; i++) begin
            if (i == 64) check_val("mdto_pre", 64'(bus.md_timeout), 64'h0);
            cyc($sformatf("mdto_wait%0d", i), C_STALL);
        end
        check_val("mdto_set", 64'(bus.md_timeout), 64'h1);
        cyc("mdto_release", C_NONE);
        check_val("mdto_sticky", 64'(bus.md_timeout), 64'h1);
        check_val("mdto_stall", 64'(bus.stall_cycles), 64'(exp_stall));

        // Reset in the middle of DRAIN
        bus.irq_req = 1'b1;
        bus.irq_en  = 1'b1;
        bus.id_pc   = 32'h0040_0080;
        cyc("rstd_entry", C_DRAIN);
        idle();
        reset = 1'b1;
        cyc("rstd_in_drain", C_NONE);
        reset = 1'b0;
        exp_stall = 0;
        check_val("rstd_epc", 64'(bus.epc), 64'h0);
        check_val("rstd_stall", 64'(bus.stall_cycles), 64'h0);
        check_val("rstd_mdto", 64'(bus.md_timeout), 64'h0);
        cyc("rstd_run", C_NONE);

        // Saturation on a narrow counter: long stall must stop at all-ones
        check_val("sat_zero", 64'(sbus.stall_cycles), 64'h0);
        sbus.ex_md_start = 1'b1;
        @(posedge clk);
        #1;
        idle_sat();
        check_val("sat_one", 64'(sbus.stall_cycles), 64'h1);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        check_val("sat_reach", 64'(sbus.stall_cycles), 64'hF);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check_val("sat_hold", 64'(sbus.stall_cycles), 64'hF);

        check_val("sb_drained", 64'(sb_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
